// File: rtl/pipe_resp_checker.sv
// Receiving-end checker for the dual-input gated delay pipeline: models the expected
// response with a LATENCY-deep history and compares it with dut_out. Optional HALT: PIPE_RESP_CHECKER_HALT_EN.
module pipe_resp_checker #(
  parameter int LATENCY   = 6,
  parameter int GATE_MODE = 0,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             in1,
  input  logic             in2,
  input  logic             dut_out,
  output logic             checking,
  output logic             err,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] checked_cnt,
  output logic [CNT_W-1:0] first_err_idx
);

  localparam int FILL_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

`ifdef PIPE_RESP_CHECKER_HALT_EN
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_CHECK, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_CHECK} state_t;
`endif

  state_t               r_state;
  state_t               w_next;
  logic [LATENCY-1:0]   r_hist;
  logic [FILL_W-1:0]    r_fill;
  logic                 r_err;
  logic [CNT_W-1:0]     r_mis_cnt;
  logic [CNT_W-1:0]     r_chk_cnt;
  logic [CNT_W-1:0]     r_first_idx;

  logic                 w_exp_in;
  logic                 w_exp_d;
  logic                 w_load;
  logic                 w_shift;
  logic                 w_cmp;
  logic                 w_mis;

  assign w_exp_in = (GATE_MODE != 0) ? (in2 & ~in1) : in2;
  assign w_exp_d  = r_hist[LATENCY-1];
  assign w_mis    = w_cmp & (dut_out != w_exp_d);

  // The edge that fills the last history slot is also the first compare, so CHECK is
  // reported from the same edge that checks the first stimulus sample.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    w_next  = r_state;
    w_load  = 1'b0;
    w_shift = 1'b0;
    w_cmp   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_next = S_FILL;
          w_load = 1'b1;
        end
      end
      S_FILL: begin
        if (!en) begin
          w_next = S_IDLE;
        end else begin
          w_shift = 1'b1;
          if (r_fill == FILL_LAST) begin
            w_cmp  = 1'b1;
            w_next = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (!en) begin
          w_next = S_IDLE;
        end else begin
          w_shift = 1'b1;
          w_cmp   = 1'b1;
        end
      end
`ifdef PIPE_RESP_CHECKER_HALT_EN
      S_HALT: begin
        if (clr) w_next = S_IDLE;
      end
`endif
      default: w_next = S_IDLE;
    endcase
`ifdef PIPE_RESP_CHECKER_HALT_EN
    if (w_mis) w_next = S_HALT;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_fill  <= '0;
    end else begin
      r_state <= w_next;
      if (w_load)
        r_fill <= '0;
      else if (r_state == S_FILL && r_fill != FILL_LAST)
        r_fill <= r_fill + FILL_W'(1);
    end
  end

  // Entering FILL restarts the history from empty so stale samples can never be compared.
  always_ff @(posedge clk) begin
    // NOTE: the history is a plain shift register, so it is cleared on reset like any other state.
    if (!reset)
      r_hist <= '0;
    else if (w_load)
      r_hist <= LATENCY'(w_exp_in);
    else if (w_shift)
      r_hist <= LATENCY'({r_hist, w_exp_in});
  end

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      r_err       <= 1'b0;
      r_mis_cnt   <= '0;
      r_chk_cnt   <= '0;
      r_first_idx <= '0;
    end else if (w_cmp) begin
      if (r_chk_cnt != CNT_MAX) r_chk_cnt <= r_chk_cnt + CNT_W'(1);
      if (w_mis) begin
        r_err <= 1'b1;
        if (r_mis_cnt != CNT_MAX) r_mis_cnt <= r_mis_cnt + CNT_W'(1);
        if (!r_err) r_first_idx <= r_chk_cnt;
      end
    end
  end

  assign checking      = (r_state == S_CHECK);
  assign err           = r_err;
  assign mismatch_cnt  = r_mis_cnt;
  assign checked_cnt   = r_chk_cnt;
  assign first_err_idx = r_first_idx;

endmodule

// File: tb/tb_pipe_resp_checker.sv
// Directed bench for pipe_resp_checker: a queue models the checked pipeline (expected
// bits pushed at drive, popped as dut_out LATENCY edges later); u1 covers gating and saturation.
module tb_pipe_resp_checker;

  localparam int L0 = 6;
  localparam int L1 = 3;

  logic       clk = 1'b0;
  logic       reset, clr;
  logic       en0, in1_0, in2_0, dout0;
  logic       en1, in1_1, in2_1, dout1;
  logic       chk0, err0, chk1, err1;
  logic [7:0] mis0, cc0, fe0;
  logic [3:0] mis1, cc1, fe1;

  int checks   = 0;
  int failures = 0;
  bit q[$];
  logic pat [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  pipe_resp_checker #(.LATENCY(L0), .GATE_MODE(0), .CNT_W(8)) u0 (
    .clk(clk), .reset(reset), .en(en0), .clr(clr), .in1(in1_0), .in2(in2_0),
    .dut_out(dout0), .checking(chk0), .err(err0), .mismatch_cnt(mis0),
    .checked_cnt(cc0), .first_err_idx(fe0)
  );

  pipe_resp_checker #(.LATENCY(L1), .GATE_MODE(1), .CNT_W(4)) u1 (
    .clk(clk), .reset(reset), .en(en1), .clr(clr), .in1(in1_1), .in2(in2_1),
    .dut_out(dout1), .checking(chk1), .err(err1), .mismatch_cnt(mis1),
    .checked_cnt(cc1), .first_err_idx(fe1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit after the rising edge.
  task automatic step(input logic e0, input logic e1, input logic c, input logic s, input logic fl);
    @(negedge clk);
    en0   = e0;
    en1   = e1;
    clr   = c;
    in2_0 = s;
    in1_0 = 1'($urandom_range(0, 1));
    q.push_back(s);
    if (q.size() > L0) dout0 = q.pop_front() ^ fl;
    else               dout0 = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    en0   = 1'b1;
    en1   = 1'b1;
    clr   = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    en0   = 1'b0;
    en1   = 1'b0;
    q.delete();
  endtask

  task automatic chk_zero0(input string tag);
    chk({tag, "_checking"}, 32'(chk0), 0);
    chk({tag, "_err"},      32'(err0), 0);
    chk({tag, "_mis"},      32'(mis0), 0);
    chk({tag, "_checked"},  32'(cc0),  0);
    chk({tag, "_first"},    32'(fe0),  0);
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0;
    en0 = 1'b0; in1_0 = 1'b0; in2_0 = 1'b0; dout0 = 1'b0;
    en1 = 1'b0; in1_1 = 1'b1; in2_1 = 1'b1; dout1 = 1'b1;

    // Reset with en held high: reset has priority.
    do_reset();
    chk_zero0("rst");
    chk("rst_u1_checked", 32'(cc1), 0);
    chk("rst_u1_err",     32'(err1), 0);

    // Gated mode, in1=in2=1 gives expected 0 against dut_out=1: every compare mismatches.
    for (int i = 0; i <= 22; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 2) begin
        chk("gate_pre_checking", 32'(chk1), 0);
        chk("gate_pre_checked",  32'(cc1),  0);
      end
`ifndef PIPE_RESP_CHECKER_HALT_EN
      if (i == 3) chk("gate_first_checking", 32'(chk1), 1);
      if (i == 12) begin
        chk("gate_mis10",   32'(mis1), 10);
        chk("gate_chk10",   32'(cc1),  10);
        chk("gate_first0",  32'(fe1),  0);
        chk("gate_err",     32'(err1), 1);
      end
      if (i == 22) begin
        chk("sat_mis",   32'(mis1), 15);
        chk("sat_chk",   32'(cc1),  15);
        chk("sat_first", 32'(fe1),  0);
      end
`else
      if (i == 3 || i == 22) begin
        chk("gate_halt_checking", 32'(chk1), 0);
        chk("gate_halt_chk",      32'(cc1),  1);
        chk("gate_halt_mis",      32'(mis1), 1);
        chk("gate_halt_err",      32'(err1), 1);
      end
`endif
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Clean run: in2 pattern, dut_out = in2 delayed L0.
    for (int i = 0; i <= 13; i++) begin
      step(1'b1, 1'b0, 1'b0, (i < 8) ? pat[i] : 1'b0, 1'b0);
      if (i == 5) begin
        chk("t1_pre_checking", 32'(chk0), 0);
        chk("t1_pre_checked",  32'(cc0),  0);
      end
      if (i == 6) begin
        chk("t1_first_checking", 32'(chk0), 1);
        chk("t1_first_checked",  32'(cc0),  1);
      end
    end
    chk("t1_checked", 32'(cc0),  8);
    chk("t1_mis",     32'(mis0), 0);
    chk("t1_err",     32'(err0), 0);
    chk("t1_first",   32'(fe0),  0);

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_retain_checked", 32'(cc0), 8);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("idle_clr_checked", 32'(cc0), 0);

`ifndef PIPE_RESP_CHECKER_HALT_EN
    // Same pattern, third compared sample corrupted.
    for (int i = 0; i <= 13; i++) begin
      step(1'b1, 1'b0, 1'b0, (i < 8) ? pat[i] : 1'b0, (i == 8));
      if (i == 7) chk("t2_pre_err", 32'(err0), 0);
      if (i == 8) begin
        chk("t2_err",     32'(err0), 1);
        chk("t2_mis",     32'(mis0), 1);
        chk("t2_first",   32'(fe0),  2);
        chk("t2_checked", 32'(cc0),  3);
      end
    end
    chk("t2_end_checked", 32'(cc0),  8);
    chk("t2_end_mis",     32'(mis0), 1);
    chk("t2_end_first",   32'(fe0),  2);

    // Drop en for one cycle, then refill before any compare.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("drop_checking", 32'(chk0), 0);
    chk("drop_checked",  32'(cc0),  8);
    chk("drop_err",      32'(err0), 1);
    for (int i = 1; i <= 7; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      if (i == 6) begin
        chk("refill_checking", 32'(chk0), 0);
        chk("refill_checked",  32'(cc0),  8);
      end
      if (i == 7) begin
        chk("reentry_checking", 32'(chk0), 1);
        chk("reentry_checked",  32'(cc0),  9);
        chk("reentry_mis",      32'(mis0), 1);
      end
    end

    // clr coincident with a mismatch wins.
    step(1'b1, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
    chk("clrmis_err",     32'(err0), 0);
    chk("clrmis_mis",     32'(mis0), 0);
    chk("clrmis_checked", 32'(cc0),  0);
    chk("clrmis_first",   32'(fe0),  0);
    step(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    chk("postclr_checked",  32'(cc0),  1);
    chk("postclr_checking", 32'(chk0), 1);
    chk("postclr_err",      32'(err0), 0);
`else
    // Fourth compared sample corrupted: FSM halts on that edge.
    for (int i = 0; i <= 9; i++) begin
      step(1'b1, 1'b0, 1'b0, (i < 8) ? pat[i] : 1'b0, (i == 9));
    end
    chk("halt_checked",  32'(cc0),  4);
    chk("halt_mis",      32'(mis0), 1);
    chk("halt_err",      32'(err0), 1);
    chk("halt_first",    32'(fe0),  3);
    chk("halt_checking", 32'(chk0), 0);
    for (int i = 0; i < 4; i++) begin
      step(1'(i % 2), 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
      chk("halt_frozen_checked",  32'(cc0),  4);
      chk("halt_frozen_checking", 32'(chk0), 0);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("halt_clr_checked", 32'(cc0),  0);
    chk("halt_clr_err",     32'(err0), 0);
    for (int i = 0; i <= 6; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      if (i == 5) chk("rehalt_pre_checking", 32'(chk0), 0);
      if (i == 6) begin
        chk("rehalt_checking", 32'(chk0), 1);
        chk("rehalt_checked",  32'(cc0),  1);
      end
    end
    step(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
    chk("halt2_checked",  32'(cc0),  2);
    chk("halt2_first",    32'(fe0),  1);
    chk("halt2_checking", 32'(chk0), 0);
    do_reset();
    chk_zero0("halt_rst");
    for (int i = 0; i <= 6; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      if (i == 6) chk("post_rst_checking", 32'(chk0), 1);
    end
`endif

    do_reset();
    chk_zero0("final_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_resp_checker.md
Name: pipe_resp_checker

Overview:
- Receiving-end checker for the dual-input gated delay pipeline.
- Samples the pipeline's stimulus inputs (in1, in2) and its response (dut_out).
- Keeps its own delayed model of the expected response and compares it with dut_out every cycle once history is full.
- Reports a sticky error, a saturating mismatch count, a checked-sample count and the index of the first failing sample; sits beside the pipeline in the test harness.

Parameters:
LATENCY, 6, input-to-output delay in cycles of the checked pipeline (3 input stages + 3 output stages); legal 1..32
GATE_MODE, 0, 0: expected = in2 (gate input tied high); 1: expected = in2 & ~in1 (inverter on in1 path)
CNT_W, 8, width of all counters and the first-error index

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  synchronous, active-low reset
en  input  1  1 = checking enabled; 0 = return to IDLE
clr  input  1  synchronous clear of err, counters and first_err_idx; does not affect FSM or history
in1  input  1  stimulus bit 1, same value the pipeline samples
in2  input  1  stimulus bit 2, same value the pipeline samples
dut_out  input  1  pipeline response
checking  output  1  1 while FSM is in CHECK
err  output  1  sticky mismatch flag
mismatch_cnt  output  CNT_W  saturating count of mismatches
checked_cnt  output  CNT_W  saturating count of compared samples
first_err_idx  output  CNT_W  value of checked_cnt at the first mismatch

Behaviour:
- Reset (reset=0 at an edge):
  - FSM goes to IDLE; history shift register and fill counter are zeroed.
  - checking=0, err=0, mismatch_cnt=0, checked_cnt=0, first_err_idx=0.
- Expected bit: exp_in = GATE_MODE ? (in2 & ~in1) : in2, computed combinationally from the inputs.
- History: a LATENCY-deep shift register shifts exp_in in on every edge in FILL and CHECK. Its last stage, exp_d, is exp_in delayed by LATENCY cycles.
- FSM states IDLE, FILL, CHECK (plus HALT when the optional feature is enabled):
  - IDLE: history is not shifted. If en=1 at an edge, go to FILL with fill_cnt=0; that edge's exp_in is the first history entry.
  - FILL: fill_cnt increments each edge. When fill_cnt reaches LATENCY-1 and en=1, go to CHECK. If en=0, go to IDLE.
  - CHECK: compare dut_out with exp_d each edge. If en=0, go to IDLE and retain all counters and err.
- Timing: if en rises at edge k, the first comparison happens at edge k+LATENCY and checks the stimulus sampled at edge k. checking=1 from edge k+LATENCY.
- Comparison, at each CHECK edge:
  - checked_cnt increments, saturating at 2^CNT_W-1.
  - If dut_out != exp_d:
    - mismatch_cnt increments, saturating.
    - err is set.
    - If err was 0 before this edge, first_err_idx takes the pre-increment value of checked_cnt.
- Counters and err update on the same edge the sample is compared (registered, visible after that edge).
- Re-entry: going from IDLE back to FILL always refills from empty. No comparison is made on stale history.
- clr=1 zeroes err, mismatch_cnt, checked_cnt and first_err_idx at that edge. If a mismatch coincides with clr, clr wins (all zero). History and FSM are unaffected.
- reset has priority over clr and en.
- Saturation: once a counter reaches all-ones it holds; err still sets.

Optional Feature:
- Macro: PIPE_RESP_CHECKER_HALT_EN.
- Defined:
  - The first mismatch moves the FSM from CHECK to HALT on the same edge.
  - In HALT there are no comparisons and no history shifting; counters freeze and checking=0.
  - HALT exits to IDLE only on clr=1 or reset; en is ignored in HALT.
- Undefined: no HALT state exists; checking continues after mismatches.

Test Plan:
- LATENCY=6, GATE_MODE=0. Reset, en=1 at edge 0, in2 pattern 1,0,1,1,0,0,1,0; dut_out = in2 delayed 6. Required: checking=1 from edge 6; after 8 compares checked_cnt=8, mismatch_cnt=0, err=0.
- Same setup, dut_out inverted on the 3rd compared sample only. Required: err=1 and mismatch_cnt=1 after that edge, first_err_idx=2, checked_cnt continues to 8.
- GATE_MODE=1, in1=1, in2=1 constant; dut_out=1 for all samples. Required: every compare mismatches; mismatch_cnt=10 after 10 compares, first_err_idx=0.
- CNT_W=4, constant mismatch for 20 compares. Required: mismatch_cnt=15 and checked_cnt=15 (both hold).
- Drop en for 1 cycle mid-CHECK, then re-raise. Required: no compares for LATENCY cycles after re-entry, counters retained; clr=1 concurrent with a mismatch leaves all counters and err at 0.
- PIPE_RESP_CHECKER_HALT_EN defined, mismatch on the 4th sample. Required: HALT entered, checked_cnt frozen at 4, checking=0; en toggling has no effect; clr returns FSM to IDLE; reset=0 mid-HALT returns everything to its reset values.
